// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: takes bitstream words over valid/ready, shifts
// them MSB-first onto the head of a ccff chain and stops after exactly
// CHAIN_LEN bits, flagging short, long or aborted bitstreams through err.
module ccff_chain_loader #(
  parameter int unsigned CHAIN_LEN = 36,
  parameter int unsigned DATA_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic              bs_valid,
  input  logic [DATA_W-1:0] bs_data,
  input  logic              bs_last,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WB_W  = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [DATA_W-1:0]  sreg;
  logic [DATA_W-1:0]  sreg_nxt;
  logic               last_word;
  logic               last_word_nxt;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   bit_cnt_nxt;
  logic [WB_W-1:0]    word_bits;
  logic [WB_W-1:0]    word_bits_nxt;

  logic               ready_nxt;
  logic               head_nxt;
  logic               shift_en_nxt;
  logic               busy_nxt;
  logic               done_nxt;
  logic               err_nxt;

  logic               xfer;
  logic               final_bit;
  logic               word_end;

  // Handshake and end-of-chain / end-of-word qualifiers for the current SHIFT cycle.
  assign xfer      = bs_valid & bs_ready;
  assign final_bit = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign word_end  = (word_bits == WB_W'(DATA_W - 1));

  // State register.
  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort outranks every other transition while loading.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (abort) begin
          state_nxt = DONE;
        end else if (xfer) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_nxt = DONE;
        end else if (final_bit) begin
          state_nxt = DONE;
        end else if (word_end) begin
          state_nxt = last_word ? DONE : FETCH;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output and datapath next values; everything here is registered below.
  always_comb begin
    sreg_nxt      = sreg;
    last_word_nxt = last_word;
    bit_cnt_nxt   = bit_cnt;
    word_bits_nxt = word_bits;
    head_nxt      = ccff_head;
    shift_en_nxt  = 1'b0;
    done_nxt      = 1'b0;
    err_nxt       = err;
    ready_nxt     = (state_nxt == FETCH);
    busy_nxt      = (state_nxt != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          bit_cnt_nxt   = '0;
          word_bits_nxt = '0;
          err_nxt       = 1'b0;
        end
      end
      FETCH: begin
        if (abort) begin
          err_nxt = 1'b1;
        end else if (xfer) begin
          sreg_nxt      = bs_data;
          last_word_nxt = bs_last;
          word_bits_nxt = '0;
        end
      end
      SHIFT: begin
        if (abort) begin
          err_nxt = 1'b1;
        end else begin
          head_nxt      = sreg[DATA_W-1];
          shift_en_nxt  = 1'b1;
          sreg_nxt      = sreg << 1;
          bit_cnt_nxt   = bit_cnt + CNT_W'(1);
          word_bits_nxt = word_bits + WB_W'(1);
          // Chain full before the bitstream said last: long bitstream.
          if (final_bit && !last_word) begin
            err_nxt = 1'b1;
          end
          // Bitstream ended before the chain was full: short bitstream.
          if (!final_bit && word_end && last_word) begin
            err_nxt = 1'b1;
          end
        end
      end
      DONE: begin
        done_nxt = 1'b1;
      end
      default: begin
        done_nxt = 1'b0;
      end
    endcase
  end

  // Registered outputs and datapath.
  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      sreg          <= '0;
      last_word     <= 1'b0;
      bit_cnt       <= '0;
      word_bits     <= '0;
      bs_ready      <= 1'b0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      sreg          <= sreg_nxt;
      last_word     <= last_word_nxt;
      bit_cnt       <= bit_cnt_nxt;
      word_bits     <= word_bits_nxt;
      bs_ready      <= ready_nxt;
      ccff_head     <= head_nxt;
      ccff_shift_en <= shift_en_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      err           <= err_nxt;
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader driving a 36-bit chain model.
module tb_ccff_chain_loader;

  logic       clk = 1'b0;
  logic       rst_l;
  logic       start;
  logic       abort;
  logic       bs_valid;
  logic [7:0] bs_data;
  logic       bs_last;
  logic       bs_ready;
  logic       ccff_head;
  logic       ccff_shift_en;
  logic       busy;
  logic       done;
  logic       err;

  logic [35:0] chain;
  int          sh_cnt;
  int          xfer_cnt;
  int          done_cnt;
  logic        clr;
  int          gap_sh;
  int          n_cmp;
  int          n_bad;

  ccff_chain_loader #(.CHAIN_LEN(36), .DATA_W(8)) dut (
    .prog_clk      (clk),
    .pReset        (rst_l),
    .start         (start),
    .abort         (abort),
    .bs_valid      (bs_valid),
    .bs_data       (bs_data),
    .bs_last       (bs_last),
    .bs_ready      (bs_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  // Chain model plus transfer / shift / done counters.
  always @(posedge clk) begin
    if (clr) begin
      chain    <= '0;
      sh_cnt   <= 0;
      xfer_cnt <= 0;
      done_cnt <= 0;
    end else begin
      if (ccff_shift_en) begin
        chain  <= {chain[34:0], ccff_head};
        sh_cnt <= sh_cnt + 1;
      end
      if (bs_valid && bs_ready) xfer_cnt <= xfer_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  function automatic logic [7:0] pat(input int i);
    case (i)
      0:       pat = 8'hA5;
      1:       pat = 8'h3C;
      2:       pat = 8'hFF;
      3:       pat = 8'h00;
      default: pat = 8'h96;
    endcase
  endfunction

  task automatic clear_model();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one word until accepted; optionally hold valid low for a gap once back in FETCH.
  task automatic feed(input logic [7:0] w, input logic l, input int gap);
    bit ok;
    ok = 1'b0;
    bs_data  = w;
    bs_last  = l;
    bs_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (bs_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL feed_accept word=%h got bs_ready=0 for 100 cycles want 1", w);
    end
    if (gap > 0) begin
      bs_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (bs_ready) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk);
      end
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL gap_refetch got bs_ready=0 for 100 cycles want 1");
      end
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        if (ccff_shift_en) gap_sh++;
      end
    end
  endtask

  task automatic load(input int n, input bit set_last, input int gap);
    for (int i = 0; i < n; i++) begin
      feed(pat(i), (set_last && (i == n - 1)), (i < n - 1) ? gap : 0);
    end
    bs_valid = 1'b0;
    bs_last  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s_done_timeout got done=0 for 300 cycles want 1", name);
    end
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bs_ready, ccff_head, ccff_shift_en, busy, done, err} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%b want=000000",
               {bs_ready, ccff_head, ccff_shift_en, busy, done, err});
    end
    rst_l = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bs_ready, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_idle got ready,busy=%b want=00", {bs_ready, busy});
    end
  endtask

  task automatic test_nominal();
    clear_model();
    do_start();
    n_cmp++;
    if ({bs_ready, busy, err} !== 3'b110) begin
      n_bad++;
      $display("FAIL t1_start got ready,busy,err=%b want=110", {bs_ready, busy, err});
    end
    load(5, 1'b1, 0);
    wait_done("t1");
    n_cmp++;
    if (chain !== 36'hA53CFF009) begin
      n_bad++;
      $display("FAIL t1_chain got=%h want=a53cff009", chain);
    end
    n_cmp++;
    if (sh_cnt !== 36) begin
      n_bad++;
      $display("FAIL t1_shift_count got=%0d want=36", sh_cnt);
    end
    n_cmp++;
    if ({err, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL t1_err_busy got=%b want=00", {err, busy});
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || done_cnt !== 1) begin
      n_bad++;
      $display("FAIL t1_done_pulse got done=%b count=%0d want done=0 count=1", done, done_cnt);
    end
  endtask

  task automatic test_short();
    clear_model();
    do_start();
    load(3, 1'b1, 0);
    wait_done("t2");
    n_cmp++;
    if (sh_cnt !== 24 || chain !== 36'h000A53CFF) begin
      n_bad++;
      $display("FAIL t2_shift got count=%0d chain=%h want 24 000a53cff", sh_cnt, chain);
    end
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL t2_err got=%b want=1", err);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL t2_after got busy,done=%b want=00", {busy, done});
    end
  endtask

  task automatic test_long();
    clear_model();
    do_start();
    load(5, 1'b0, 0);
    bs_data  = 8'h77;
    bs_last  = 1'b1;
    bs_valid = 1'b1;
    wait_done("t3");
    repeat (3) @(negedge clk);
    bs_valid = 1'b0;
    bs_last  = 1'b0;
    n_cmp++;
    if (sh_cnt !== 36 || chain !== 36'hA53CFF009) begin
      n_bad++;
      $display("FAIL t3_shift got count=%0d chain=%h want 36 a53cff009", sh_cnt, chain);
    end
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL t3_err got=%b want=1", err);
    end
    n_cmp++;
    if (xfer_cnt !== 5) begin
      n_bad++;
      $display("FAIL t3_transfers got=%0d want=5", xfer_cnt);
    end
  endtask

  task automatic test_gaps();
    clear_model();
    gap_sh = 0;
    do_start();
    load(5, 1'b1, 5);
    wait_done("t4");
    n_cmp++;
    if (gap_sh !== 0) begin
      n_bad++;
      $display("FAIL t4_gap_shift got=%0d shift cycles in gaps want=0", gap_sh);
    end
    n_cmp++;
    if (sh_cnt !== 36 || chain !== 36'hA53CFF009) begin
      n_bad++;
      $display("FAIL t4_chain got count=%0d chain=%h want 36 a53cff009", sh_cnt, chain);
    end
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL t4_err got=%b want=0", err);
    end
  endtask

  task automatic test_abort();
    bit ok;
    clear_model();
    do_start();
    feed(pat(0), 1'b0, 0);
    feed(pat(1), 1'b0, 0);
    bs_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (sh_cnt == 11) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL t5_reach11 got count=%0d want=11", sh_cnt);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++;
    if ({ccff_shift_en, err, bs_ready} !== 3'b010) begin
      n_bad++;
      $display("FAIL t5_abort got shift_en,err,ready=%b want=010", {ccff_shift_en, err, bs_ready});
    end
    wait_done("t5");
    n_cmp++;
    if (sh_cnt !== 12 || chain !== 36'h000000A53) begin
      n_bad++;
      $display("FAIL t5_partial got count=%0d chain=%h want 12 000000a53", sh_cnt, chain);
    end
    @(negedge clk);
    clear_model();
    do_start();
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL t5_err_clear got=%b want=0", err);
    end
    load(5, 1'b1, 0);
    wait_done("t5b");
    n_cmp++;
    if (sh_cnt !== 36 || chain !== 36'hA53CFF009 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL t5_reload got count=%0d chain=%h err=%b want 36 a53cff009 0", sh_cnt, chain, err);
    end
  endtask

  task automatic test_busy_start();
    clear_model();
    do_start();
    feed(pat(0), 1'b0, 0);
    feed(pat(1), 1'b0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({busy, bs_ready, err} !== 3'b100) begin
      n_bad++;
      $display("FAIL t6_start_busy got busy,ready,err=%b want=100", {busy, bs_ready, err});
    end
    feed(pat(2), 1'b0, 0);
    feed(pat(3), 1'b0, 0);
    feed(pat(4), 1'b1, 0);
    bs_valid = 1'b0;
    bs_last  = 1'b0;
    wait_done("t6a");
    n_cmp++;
    if (sh_cnt !== 36 || chain !== 36'hA53CFF009 || err !== 1'b0 || xfer_cnt !== 5) begin
      n_bad++;
      $display("FAIL t6_ignored_start got count=%0d chain=%h err=%b xfers=%0d want 36 a53cff009 0 5",
               sh_cnt, chain, err, xfer_cnt);
    end
  endtask

  task automatic test_reset_mid();
    clear_model();
    do_start();
    feed(pat(0), 1'b0, 0);
    repeat (3) @(negedge clk);
    rst_l = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bs_ready, ccff_head, ccff_shift_en, busy, done, err} !== 6'b0) begin
      n_bad++;
      $display("FAIL t6_reset_mid got=%b want=000000",
               {bs_ready, ccff_head, ccff_shift_en, busy, done, err});
    end
    rst_l = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (xfer_cnt !== 1 || bs_ready !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL t6_idle_valid got xfers=%0d ready=%b busy=%b want 1 0 0", xfer_cnt, bs_ready, busy);
    end
    bs_valid = 1'b0;
  endtask

  task automatic test_start_abort();
    clear_model();
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    n_cmp++;
    if ({bs_ready, busy, err} !== 3'b110) begin
      n_bad++;
      $display("FAIL start_wins got ready,busy,err=%b want=110", {bs_ready, busy, err});
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++;
    if ({bs_ready, busy, err} !== 3'b011) begin
      n_bad++;
      $display("FAIL fetch_abort got ready,busy,err=%b want=011", {bs_ready, busy, err});
    end
    wait_done("abort_fetch");
    n_cmp++;
    if (sh_cnt !== 0 || err !== 1'b1) begin
      n_bad++;
      $display("FAIL fetch_abort_end got count=%0d err=%b want 0 1", sh_cnt, err);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    gap_sh   = 0;
    clr      = 1'b1;
    rst_l    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    bs_valid = 1'b0;
    bs_data  = 8'h00;
    bs_last  = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    test_reset();
    test_nominal();
    test_short();
    test_long();
    test_gaps();
    test_abort();
    test_busy_start();
    test_reset_mid();
    test_start_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
